// File: rtl/pipeline_adder.sv
// Two-stage pipelined signed three-operand adder: S = A + B + C, two edges after sampling.
// Define PIPELINE_ADDER_SAT_EN for exact-width saturating arithmetic with the ovf flag.
module pipeline_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] debug_sum_stage1,
  output logic [WIDTH-1:0] debug_C_stage1
`ifdef PIPELINE_ADDER_SAT_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] c_stage1_d, c_stage1_q;
  logic [WIDTH-1:0] s_d, s_q;

`ifdef PIPELINE_ADDER_SAT_EN
  // Stage 1 keeps the exact A+B; clamping only affects the debug view.
  logic [WIDTH:0]   sum_stage1_d, sum_stage1_q;
  logic [WIDTH+1:0] exact2;
  logic             ovf_d, ovf_q;

  always_comb begin
    sum_stage1_d = '0;
    c_stage1_d   = '0;
    if (rst) begin
      sum_stage1_d = {A[WIDTH-1], A} + {B[WIDTH-1], B};
      c_stage1_d   = C;
    end
  end

  always_comb begin
    exact2 = {sum_stage1_q[WIDTH], sum_stage1_q} + {{2{c_stage1_q[WIDTH-1]}}, c_stage1_q};
    s_d    = '0;
    ovf_d  = 1'b0;
    if (rst) begin
      if ((exact2[WIDTH+1] == exact2[WIDTH]) && (exact2[WIDTH] == exact2[WIDTH-1])) begin
        s_d = exact2[WIDTH-1:0];
      end else begin
        s_d   = exact2[WIDTH+1] ? SMIN : SMAX;
        ovf_d = 1'b1;
      end
    end
  end

  always_comb begin
    if (sum_stage1_q[WIDTH] == sum_stage1_q[WIDTH-1]) begin
      debug_sum_stage1 = sum_stage1_q[WIDTH-1:0];
    end else begin
      debug_sum_stage1 = sum_stage1_q[WIDTH] ? SMIN : SMAX;
    end
  end

  always_ff @(posedge clk) begin
    ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic [WIDTH-1:0] sum_stage1_d, sum_stage1_q;

  always_comb begin
    sum_stage1_d = '0;
    c_stage1_d   = '0;
    s_d          = '0;
    if (rst) begin
      sum_stage1_d = A + B;
      c_stage1_d   = C;
      s_d          = sum_stage1_q + c_stage1_q;
    end
  end

  assign debug_sum_stage1 = sum_stage1_q;
`endif

  // rst is folded into the _d terms, so these flops load 0 on a reset edge.
  always_ff @(posedge clk) begin
    sum_stage1_q <= sum_stage1_d;
    c_stage1_q   <= c_stage1_d;
    s_q          <= s_d;
  end

  assign debug_C_stage1 = c_stage1_q;
  assign S              = s_q;

endmodule

// File: tb/tb_pipeline_adder.sv
// Directed self-checking bench for pipeline_adder (WIDTH=32), both with and without PIPELINE_ADDER_SAT_EN.
module tb_pipeline_adder;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] A, B, C;
  logic [W-1:0] S, dbg_sum, dbg_c;
`ifdef PIPELINE_ADDER_SAT_EN
  logic         ovf;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  pipeline_adder #(.WIDTH(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .A                (A),
    .B                (B),
    .C                (C),
    .S                (S),
    .debug_sum_stage1 (dbg_sum),
    .debug_C_stage1   (dbg_c)
`ifdef PIPELINE_ADDER_SAT_EN
    ,
    .ovf              (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive a vector, clock it in, then settle 1 time unit past the edge.
  task automatic apply(input logic r, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    rst = r; A = a; B = b; C = c;
    @(posedge clk);
    #1;
  endtask

  // Stream table: A, B, C, hand-computed A+B and A+B+C.
  int va  [13] = '{   1, -100,  50, -37,  99, -100, 0,  17, -1,  73, 100, -45,  64};
  int vb  [13] = '{   2,  100, -25,  88, 100, -100, 0, -64, -1, -29,  -3,  12,  64};
  int vc  [13] = '{   3, -100,   7, -12, 100, -100, 0,  45,  1, -88, -56,  33, -27};
  int vab [13] = '{   3,    0,  25,  51, 199, -200, 0, -47, -2,  44,  97, -33, 128};
  int vs  [13] = '{   6, -100,  32,  39, 299, -300, 0,  -2, -1, -44,  41,   0, 101};

  initial begin
    // Reset held for two edges with nonzero inputs.
    apply(1'b0, 5, 5, 5);
    apply(1'b0, 5, 5, 5);
    check("rst_S",   S,       '0);
    check("rst_dsum", dbg_sum, '0);
    check("rst_dc",  dbg_c,   '0);
`ifdef PIPELINE_ADDER_SAT_EN
    check("rst_ovf", {31'd0, ovf}, '0);
`endif

    // Basic latency.
    apply(1'b1, 10, 20, -5);
    check("lat_dsum", dbg_sum, 30);
    check("lat_dc",   dbg_c,   -5);
    check("lat_S_k",  S,       0);
    apply(1'b1, 0, 0, 0);
    check("lat_S_k1", S,       25);

    // Streaming: S after capture of vector i reflects vector i-1.
    for (int i = 0; i < 13; i++) begin
      apply(1'b1, va[i], vb[i], vc[i]);
      check($sformatf("str_dsum%0d", i), dbg_sum, vab[i]);
      check($sformatf("str_dc%0d", i),   dbg_c,   vc[i]);
      if (i > 0) check($sformatf("str_S%0d", i - 1), S, vs[i-1]);
    end
    apply(1'b1, 0, 0, 0);
    check("str_S12", S, vs[12]);

    // Overflow boundaries.
    apply(1'b1, 32'h7FFF_FFFF, 32'd1, 32'd0);
`ifdef PIPELINE_ADDER_SAT_EN
    check("ovf1_dsum", dbg_sum, 32'h7FFF_FFFF);
`else
    check("ovf1_dsum", dbg_sum, 32'h8000_0000);
`endif
    apply(1'b1, 32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFF);
`ifdef PIPELINE_ADDER_SAT_EN
    check("ovf1_S",   S, 32'h7FFF_FFFF);
    check("ovf1_flag", {31'd0, ovf}, 32'd1);
`else
    check("ovf1_S",   S, 32'h8000_0000);
`endif
    apply(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("ovf2_S", S, 32'h7FFF_FFFF);
`ifdef PIPELINE_ADDER_SAT_EN
    check("ovf2_flag", {31'd0, ovf}, 32'd0);
    check("ovf3_dsum", dbg_sum, 32'h8000_0000);
`else
    check("ovf3_dsum", dbg_sum, 32'h7FFF_FFFF);
`endif
    apply(1'b1, 0, 0, 0);
`ifdef PIPELINE_ADDER_SAT_EN
    check("ovf3_S",   S, 32'h8000_0000);
    check("ovf3_flag", {31'd0, ovf}, 32'd1);
`else
    check("ovf3_S",   S, 32'h7FFF_FFFE);
`endif

    // Mid-stream reset.
    apply(1'b1, 1, 1, 1);
    apply(1'b0, 1, 1, 1);
    check("mrst_S",    S,       0);
    check("mrst_dsum", dbg_sum, 0);
    check("mrst_dc",   dbg_c,   0);
    apply(1'b1, 2, 2, 2);
    check("mrst_S1",   S,       0);
    check("mrst_dsum1", dbg_sum, 6 - 2);
    check("mrst_dc1",  dbg_c,   2);
    apply(1'b1, 0, 0, 0);
    check("mrst_S2",   S,       6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_adder.md
Name: pipeline_adder

Overview:
- Two-stage pipelined signed three-operand adder: S = A + B + C, two clock cycles after inputs are sampled.
- Stage 1 registers A+B and a delayed copy of C; stage 2 adds them.
- Stage-1 registers are exposed as debug outputs for bring-up and visibility.
- Used as an accumulation/datapath building block inside the compute cluster.

Parameters:
- WIDTH, 32, operand/result width in bits, two's complement signed.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low (rst=0 resets on the next rising clk edge)
- A  input  WIDTH  signed operand
- B  input  WIDTH  signed operand
- C  input  WIDTH  signed operand
- S  output  WIDTH  signed result, registered
- debug_sum_stage1  output  WIDTH  registered stage-1 partial sum A+B
- debug_C_stage1  output  WIDTH  registered stage-1 copy of C
- ovf  output  1  overflow/saturation flag, registered (present only with PIPELINE_ADDER_SAT_EN)

Behaviour:
- All outputs are registers; no combinational path from inputs to outputs.
- Reset: on a rising edge with rst=0, sum_stage1, C_stage1, S (and ovf) all become 0, regardless of inputs.
- Stage 1, on each rising edge with rst=1:
  - sum_stage1 <= A + B
  - C_stage1 <= C
- Stage 2, on the same edge: S <= sum_stage1 + C_stage1, using stage-1 values from before the edge.
- Latency: inputs sampled at edge k → debug outputs valid after edge k; S valid after edge k+1.
- Throughput: one new operand set per cycle, no stalls, no handshake. Inputs must be stable around each rising edge.
- Arithmetic, without the macro: two's complement modulo 2^WIDTH at each stage.
  - Example: 0x7FFFFFFF + 1 wraps to 0x80000000. No flags.
- Reset mid-stream: the whole pipeline flushes to 0 on that edge.
  - The first edge with rst=1 captures new inputs into stage 1.
  - On that same edge S <= 0 + 0 = 0.
  - Valid S resumes one edge later.
- Reset held low for multiple cycles: outputs stay 0.
- Simultaneous input change and clock edge: the value present at the edge is captured. No X-propagation requirements beyond standard flop behaviour.

Optional Feature:
- Macro: PIPELINE_ADDER_SAT_EN
- Defined:
  - Stage 1 internally keeps a WIDTH+1-bit exact A+B.
  - debug_sum_stage1 shows that value clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Stage 2 computes the exact WIDTH+2-bit sum of the exact stage-1 value and C_stage1, then clamps it to the signed WIDTH range.
  - ovf is registered alongside S: 1 when clamping occurred on the stage-2 result, else 0. Reset value 0.
  - Intermediate overflow of A+B that cancels with C gives the exact result with ovf=0.
- Not defined: wrap-around arithmetic as above; port ovf does not exist.

Test Plan:
- Reset: rst=0 for 2 edges with A=B=C=5 → S=0, debug_sum_stage1=0, debug_C_stage1=0.
- Basic latency: release rst, apply A=10, B=20, C=-5 at edge k.
  - debug_sum_stage1=30 and debug_C_stage1=-5 after edge k.
  - S=25 after edge k+1.
- Streaming: apply (1,2,3), (-100,100,-100), (50,-25,7) on consecutive edges → S = 6, -100, 32 on consecutive edges, two cycles after each input.
- Random signed in [-100,100]: 10 consecutive vectors → each S equals A+B+C of the vector applied two edges earlier.
- Overflow: A=0x7FFFFFFF, B=1, C=0.
  - Without macro: S=0x80000000.
  - With macro: S=0x7FFFFFFF, ovf=1.
  - With macro, A=0x7FFFFFFF, B=1, C=-1 → S=0x7FFFFFFF, ovf=0.
- Mid-stream reset: stream (1,1,1), then rst=0 for one edge, then resume with (2,2,2).
  - After the reset edge: S=0 and both debug outputs = 0.
  - Next edge: S=0.
  - Edge after that: S=6.
